// File: rtl/genius_seq_engine.sv
`default_nettype none
// ============================================================================
// Module   : genius_seq_engine
// Brief    : Simon-style sequence engine: grows an LFSR colour sequence, plays
//            it back with speed-dependent timing and checks player presses.
// Revision : 1.0 - initial release
// ============================================================================
module genius_seq_engine #(
    parameter int unsigned NUM_COLORS    = 4,
    parameter int unsigned MAX_LEN       = 32,
    parameter int unsigned STEP_CYCLES   = 25000000,
    parameter int unsigned TIMEOUT_STEPS = 5,
    parameter logic [15:0] SEED          = 16'hACE1,
    localparam int unsigned CW           = $clog2(NUM_COLORS),
    localparam int unsigned SW           = $clog2(MAX_LEN + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_COLORS-1:0] btn,
    input  logic [1:0]            velocity,
    output logic [CW-1:0]         color_out,
    output logic                  color_valid,
    output logic [SW-1:0]         score,
    output logic                  busy,
    output logic                  win,
    output logic                  fail,
    output logic [2:0]            state
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_STEPS * STEP_CYCLES + 1);

    localparam logic [TW-1:0]         c_ONE_T   = TW'(1);
    localparam logic [SW-1:0]         c_ONE_S   = SW'(1);
    localparam logic [SW-1:0]         c_MAX_LEN = SW'(MAX_LEN);
    localparam logic [NUM_COLORS-1:0] c_ONE_C   = NUM_COLORS'(1);
    localparam logic [15:0]           c_TAPS    = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_ECHO     = 3'd5,
        S_FAIL     = 3'd6,
        S_WIN      = 3'd7
    } state_t;

    function automatic int unsigned f_step(input int unsigned v);
        int unsigned t;
        t = STEP_CYCLES >> v;
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int unsigned f_gap(input int unsigned v);
        int unsigned g;
        g = f_step(v) >> 1;
        return (g == 0) ? 1 : g;
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_lfsr;
    logic [15:0]           w_lfsr_next;
    logic [CW-1:0]         r_mem [MAX_LEN];
    logic [SW-1:0]         r_len;
    logic [SW-1:0]         r_idx;
    logic [SW-1:0]         r_score;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         r_step;
    logic [TW-1:0]         r_gap;
    logic [TW-1:0]         r_tout;
    logic [CW-1:0]         r_echo;
    logic [TW-1:0]         w_step;
    logic [TW-1:0]         w_gap;
    logic [TW-1:0]         w_tout;
    logic [CW-1:0]         w_cur;
    logic                  w_last;
    logic                  w_press_ok;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
    assign w_cur       = r_mem[r_idx[IW-1:0]];
    assign w_last      = (r_idx == r_len - c_ONE_S);
    // Exact match against the expected one-hot also rejects multi-hot presses.
    assign w_press_ok  = (btn == (c_ONE_C << w_cur));

    always_comb begin
        w_step = TW'(f_step(0));
        w_gap  = TW'(f_gap(0));
        w_tout = TW'(f_step(0) * TIMEOUT_STEPS);
        case (velocity)
            2'd1: begin
                w_step = TW'(f_step(1));
                w_gap  = TW'(f_gap(1));
                w_tout = TW'(f_step(1) * TIMEOUT_STEPS);
            end
            2'd2: begin
                w_step = TW'(f_step(2));
                w_gap  = TW'(f_gap(2));
                w_tout = TW'(f_step(2) * TIMEOUT_STEPS);
            end
            2'd3: begin
                w_step = TW'(f_step(3));
                w_gap  = TW'(f_gap(3));
                w_tout = TW'(f_step(3) * TIMEOUT_STEPS);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = S_IDLE;
            S_ADD:      w_next = S_SHOW_ON;
            S_SHOW_ON: begin
                if (r_timer == r_step - c_ONE_T) w_next = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (r_timer == r_gap - c_ONE_T) w_next = w_last ? S_INPUT : S_SHOW_ON;
            end
            S_INPUT: begin
                // A press on the final timeout cycle still counts.
                if (btn != '0) begin
                    w_next = w_press_ok ? S_ECHO : S_FAIL;
                end else if (r_timer == r_tout - c_ONE_T) begin
                    w_next = S_FAIL;
                end
            end
            S_ECHO: begin
                if (r_timer == r_gap - c_ONE_T) begin
                    if (!w_last)                  w_next = S_INPUT;
                    else if (r_len == c_MAX_LEN)  w_next = S_WIN;
                    else                          w_next = S_ADD;
                end
            end
            S_FAIL:     w_next = S_FAIL;
            S_WIN:      w_next = S_WIN;
            default:    w_next = S_IDLE;
        endcase
        if (start) w_next = S_ADD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr  <= SEED;
            r_len   <= '0;
            r_idx   <= '0;
            r_score <= '0;
            r_timer <= '0;
            r_step  <= c_ONE_T;
            r_gap   <= c_ONE_T;
            r_tout  <= c_ONE_T;
            r_echo  <= '0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            // One shared timer, restarted on every state change.
            r_timer <= (w_next != r_state) ? '0 : r_timer + c_ONE_T;
            if (start) begin
                r_len   <= '0;
                r_score <= '0;
            end else begin
                case (r_state)
                    S_ADD: begin
                        r_len  <= r_len + c_ONE_S;
                        r_idx  <= '0;
                        r_step <= w_step;
                        r_gap  <= w_gap;
                        r_tout <= w_tout;
                    end
                    S_SHOW_OFF: begin
                        if (w_next != S_SHOW_OFF) r_idx <= w_last ? '0 : r_idx + c_ONE_S;
                    end
                    S_INPUT: begin
                        if (w_next == S_ECHO) r_echo <= w_cur;
                    end
                    S_ECHO: begin
                        if (w_next == S_INPUT)     r_idx   <= r_idx + c_ONE_S;
                        else if (w_next != S_ECHO) r_score <= r_len;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sequence storage needs no reset: entries are written before being read.
    always_ff @(posedge clock) begin
        if (!reset && !start && r_state == S_ADD) begin
            r_mem[r_len[IW-1:0]] <= r_lfsr[CW-1:0];
        end
    end

    always_comb begin
        color_out   = '0;
        color_valid = 1'b0;
        if (r_state == S_SHOW_ON) begin
            color_out   = w_cur;
            color_valid = 1'b1;
        end else if (r_state == S_ECHO) begin
            color_out   = r_echo;
            color_valid = 1'b1;
        end
    end

    assign score = r_score;
    assign busy  = !(r_state == S_IDLE || r_state == S_FAIL || r_state == S_WIN);
    assign win   = (r_state == S_WIN);
    assign fail  = (r_state == S_FAIL);
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_genius_seq_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_genius_seq_engine
// Brief    : Self-checking bench for genius_seq_engine (4 colours, length 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_genius_seq_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [1:0] velocity = 2'd0;
    logic [1:0] color_out;
    logic       color_valid;
    logic [2:0] score;
    logic       busy;
    logic       win;
    logic       fail;
    logic [2:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] m_lfsr = 16'hACE1;
    logic [1:0]  m_seq [4];

    typedef struct packed {
        logic       rst;
        logic       st;
        logic [3:0] b;
        logic [2:0] e_state;
        logic       e_valid;
        logic       e_busy;
    } vec_t;

    vec_t tv[$];

    genius_seq_engine #(
        .NUM_COLORS   (4),
        .MAX_LEN      (4),
        .STEP_CYCLES  (8),
        .TIMEOUT_STEPS(4),
        .SEED         (16'hACE1)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .start      (start),
        .btn        (btn),
        .velocity   (velocity),
        .color_out  (color_out),
        .color_valid(color_valid),
        .score      (score),
        .busy       (busy),
        .win        (win),
        .fail       (fail),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, x^16+x^14+x^13+x^11+1
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] b,
                                input logic [2:0] es, input logic ev, input logic eb);
        vec_t v;
        v.rst = r; v.st = s; v.b = b; v.e_state = es; v.e_valid = ev; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk_zero(input string name);
        chk(name, 32'({color_out, color_valid, score, busy, win, fail, state}), 32'd0);
    endtask

    task automatic start_game(input logic [1:0] vel);
        velocity = vel;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", 32'(state), 32'd1);
        chk("start_score_flags", 32'({score, win, fail}), 32'd0);
    endtask

    // Precondition: ADD just observed. Ends with INPUT observed.
    task automatic playback(input int L, input int T, input int G);
        m_seq[L-1] = m_lfsr[1:0];
        for (int i = 0; i < L; i++) begin
            for (int t = 0; t < T; t++) begin
                tick();
                chk("show_on_state", 32'(state), 32'd2);
                chk("show_color", 32'({color_valid, color_out}), 32'({1'b1, m_seq[i]}));
            end
            for (int g = 0; g < G; g++) begin
                tick();
                chk("show_off", 32'({state, color_valid}), 32'({3'd3, 1'b0}));
            end
        end
        tick();
        chk("input_entry", 32'(state), 32'd4);
    endtask

    task automatic press_only(input logic [1:0] col);
        btn = 4'b0001 << col;
        tick();
        btn = 4'b0000;
        chk("echo_state", 32'(state), 32'd5);
        chk("echo_color", 32'({color_valid, color_out}), 32'({1'b1, col}));
    endtask

    task automatic finish_echo(input int G, input logic [2:0] nxt);
        for (int g = 1; g < G; g++) begin
            tick();
            chk("echo_hold", 32'(state), 32'd5);
        end
        tick();
        chk("echo_exit", 32'(state), 32'(nxt));
    endtask

    task automatic play_round(input int r, input int T, input int G);
        logic [2:0] nxt;
        playback(r, T, G);
        for (int i = 0; i < r; i++) begin
            press_only(m_seq[i]);
            if (i < r - 1)  nxt = 3'd4;
            else if (r < 4) nxt = 3'd1;
            else            nxt = 3'd7;
            finish_echo(G, nxt);
        end
        chk("round_score", 32'(score), 32'(r));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then a quiet idle period with every output at zero.
        repeat (3) tick();
        chk_zero("reset_outputs");
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_zero("idle_outputs");
        end

        // Table: reset again, ignored buttons in IDLE, first round playback at velocity 0.
        for (int i = 0; i < 3; i++) tv.push_back(mk(1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 1'b0, 4'b0010, 3'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 1'b0, 4'b0100, 3'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 1'b0, 4'b1000, 3'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 1'b1, 4'b0000, 3'd1, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++) tv.push_back(mk(1'b0, 1'b0, (i == 3) ? 4'b0001 : 4'b0000, 3'd2, 1'b1, 1'b1));
        for (int i = 0; i < 4; i++) tv.push_back(mk(1'b0, 1'b0, (i == 1) ? 4'b0010 : 4'b0000, 3'd3, 1'b0, 1'b1));
        tv.push_back(mk(1'b0, 1'b0, 4'b0000, 3'd4, 1'b0, 1'b1));

        velocity = 2'd0;
        foreach (tv[i]) begin
            reset = tv[i].rst;
            start = tv[i].st;
            btn   = tv[i].b;
            tick();
            if (tv[i].e_state == 3'd1) m_seq[0] = m_lfsr[1:0];
            chk("vec_state", 32'(state), 32'(tv[i].e_state));
            chk("vec_valid_busy", 32'({color_valid, busy}), 32'({tv[i].e_valid, tv[i].e_busy}));
            chk("vec_flags_score", 32'({win, fail, score}), 32'd0);
            if (tv[i].e_valid) chk("vec_color", 32'(color_out), 32'(m_seq[0]));
        end
        reset = 1'b0;
        start = 1'b0;
        btn   = 4'b0000;

        // Full game to WIN at velocity 2 (T=2, G=1).
        start_game(2'd2);
        for (int r = 1; r <= 4; r++) play_round(r, 2, 1);
        chk("win_flags", 32'({win, fail, busy, color_valid}), 32'b1000);
        repeat (3) tick();
        chk("win_sticky", 32'({state, win, score}), 32'({3'd7, 1'b1, 3'd4}));
        start_game(2'd2);

        // Wrong colour in round 1.
        start_game(2'd2);
        playback(1, 2, 1);
        btn = 4'b0001 << (m_seq[0] ^ 2'd1);
        tick();
        btn = 4'b0000;
        chk("wrong_fail", 32'({state, fail, win, color_valid}), 32'({3'd6, 1'b1, 1'b0, 1'b0}));
        chk("wrong_score", 32'(score), 32'd0);
        btn = 4'b1111;
        tick();
        btn = 4'b0000;
        tick();
        chk("fail_sticky", 32'({state, fail}), 32'({3'd6, 1'b1}));

        // Multi-hot press in round 2: fail, score holds at 1.
        start_game(2'd2);
        play_round(1, 2, 1);
        playback(2, 2, 1);
        btn = 4'b0011;
        tick();
        btn = 4'b0000;
        chk("multihot_fail", 32'({state, fail}), 32'({3'd6, 1'b1}));
        chk("multihot_score", 32'(score), 32'd1);

        // Timeout at velocity 0: 4 steps of 8 cycles.
        start_game(2'd0);
        playback(1, 8, 4);
        repeat (31) tick();
        chk("timeout_not_yet", 32'({state, fail}), 32'({3'd4, 1'b0}));
        tick();
        chk("timeout_fail", 32'({state, fail}), 32'({3'd6, 1'b1}));

        // Press on the last timeout cycle is accepted.
        start_game(2'd0);
        playback(1, 8, 4);
        repeat (31) tick();
        press_only(m_seq[0]);
        chk("late_press_nofail", 32'(fail), 32'd0);
        finish_echo(4, 3'd1);
        chk("late_press_score", 32'(score), 32'd1);

        // Reset during SHOW_ON of round 3.
        start_game(2'd2);
        play_round(1, 2, 1);
        play_round(2, 2, 1);
        m_seq[2] = m_lfsr[1:0];
        tick();
        chk("r3_show_on", 32'({state, color_valid, color_out}), 32'({3'd2, 1'b1, m_seq[0]}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("mid_reset_outputs");
        tick();
        chk_zero("post_reset_idle");

        // Start during ECHO restarts at length 1.
        start_game(2'd2);
        play_round(1, 2, 1);
        playback(2, 2, 1);
        press_only(m_seq[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("echo_start_state", 32'(state), 32'd1);
        chk("echo_start_score", 32'(score), 32'd0);
        playback(1, 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/genius_seq_engine.md
# genius_seq_engine

Parametrised sequence engine for the Genius (Simon) memory game, replacing the fixed four-colour game FSM, random-colour source and speed counter with one block. It grows a pseudo-random colour sequence, plays it back with speed-dependent step timing, checks player button pulses against it, and reports score, win and fail. It sits between the LevelToPulse button conditioners and the VGA/7-segment display drivers.

## Interface
- NUM_COLORS, 4, number of colours/buttons; power of two, 2..16; CW = log2(NUM_COLORS)
- MAX_LEN, 32, sequence length that wins the game; 2..64; SW = clog2(MAX_LEN+1)
- STEP_CYCLES, 25000000, base step length in clock cycles at velocity 0; minimum 8
- TIMEOUT_STEPS, 5, number of steps with no player input before fail; minimum 1
- SEED, 16'hACE1, LFSR reset value; must be nonzero

- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse; starts a new game from any state
- btn  in  NUM_COLORS  one-cycle button pulses, bit i = colour i
- velocity  in  2  speed select; sampled on entry to ADD
- color_out  out  CW  colour being displayed; valid when color_valid=1
- color_valid  out  1  colour display on (playback or echo)
- score  out  SW  number of completed rounds
- busy  out  1  high in every state except IDLE, FAIL and WIN
- win  out  1  level; high in WIN
- fail  out  1  level; high in FAIL
- state  out  3  state code for debug LEDs

## Operation
- States and codes: IDLE=0, ADD=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, ECHO=5, FAIL=6, WIN=7.
- Step length T = max(1, STEP_CYCLES >> velocity), latched on ADD entry. Gap G = max(1, T >> 1).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle in every state. Reset loads SEED.
- Sequence memory: MAX_LEN x CW registers. Read is combinational. len and idx are counters.
- start (any state, reset low): len=0, score=0, win=fail=0, go to ADD.
- ADD (1 cycle): mem[len] <= lfsr[CW-1:0]; len <= len+1; idx <= 0; go to SHOW_ON.
- SHOW_ON (T cycles): color_out=mem[idx], color_valid=1. Then go to SHOW_OFF.
- SHOW_OFF (G cycles): color_valid=0. Then, if idx == len-1, set idx=0, clear the timeout timer and go to INPUT. Otherwise idx++ and go to SHOW_ON.
- btn is ignored in ADD, SHOW_ON, SHOW_OFF and ECHO.
- INPUT: wait for btn != 0.
  - Exactly one bit set and it equals mem[idx]: latch the colour and go to ECHO.
  - Wrong colour, or more than one bit set: go to FAIL.
  - Timeout timer reaches TIMEOUT_STEPS*T cycles with no press: go to FAIL.
- ECHO (G cycles): color_out = pressed colour, color_valid=1. At the end:
  - If idx < len-1: idx++, clear the timer, return to INPUT.
  - Else score <= len. If len == MAX_LEN go to WIN, else go to ADD.
- FAIL and WIN are sticky until start or reset. In both, color_valid=0 and score holds.
- start and btn in the same cycle: start wins.
- reset and start in the same cycle: reset wins.

## Timing
- Reset values: state=IDLE(0), color_out=0, color_valid=0, score=0, busy=0, win=0, fail=0; len=idx=0; LFSR=SEED.
- All outputs are registered or decoded from registers. No combinational path from input to output.
- start at edge n: state=ADD after edge n, SHOW_ON after edge n+1.
- First colour shown: the LFSR value in the ADD cycle. With reset released, start asserted k cycles after reset deassertion → the colour is the LFSR state after k+1 advances, bits [CW-1:0].
- Playback of a length-L round: L*(T+G) cycles from SHOW_ON entry to INPUT entry.
- Correct press at edge m → ECHO after edge m. After the final press, ADD or WIN after edge m+G.
- Wrong press at edge m → fail=1 after edge m.
- Timeout → fail=1 exactly TIMEOUT_STEPS*T cycles after INPUT entry, if no press.

## Test plan
- Reset/idle (STEP_CYCLES=8, NUM_COLORS=4, MAX_LEN=4, TIMEOUT_STEPS=4): hold reset 3 cycles, release → state=0, all outputs 0 for 20 cycles. btn pulses in IDLE → no change.
- Playback timing, velocity=0: start → color_valid high 8 cycles, low 4 cycles, color_out equals the model LFSR[1:0]. INPUT (state=4) entered 1+12 cycles after start.
- Full win, MAX_LEN=4, velocity=2 (T=2, G=1): echo every colour correctly each round → score steps 1,2,3,4. win=1 and state=7 after the 4th round. start then → score=0, state=1.
- Wrong and multi-hot input: in round 1, press the colour ^ 1 → fail=1 the next cycle, score=0. Repeat with btn=4'b0011 → fail=1.
- Timeout, velocity=0: reach INPUT and press nothing → fail=1 exactly 32 cycles after INPUT entry. A press at cycle 31 → no fail.
- Mid-game disruptions: reset asserted during SHOW_ON of round 3 → all outputs return to reset values the next cycle. In a separate run, start during ECHO → state=1, score=0, len=1.
